// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock, holds the system reset for a fixed window, retries the PLL on lock loss or timeout.
// Outputs are registered and follow the state register; no input backpressure.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int HOLD_CYCLES    = 256,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int PLL_RST_CYCLES = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic [2:0] state_o,
  output logic [7:0] lock_loss_cnt,
  output logic [7:0] retry_cnt
);

  localparam int MAX_AB = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int MAX_CD = (TIMEOUT_CYCLES > PLL_RST_CYCLES) ? TIMEOUT_CYCLES : PLL_RST_CYCLES;
  localparam int MAX_ALL = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W = $clog2(MAX_ALL) + 1;

  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RUN       = 3'd3,
    ST_PLL_RST   = 3'd4
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   sys_reset_q, sys_reset_d;
  logic                   ready_q, ready_d;
  logic [7:0]             lock_loss_cnt_q, lock_loss_cnt_d;
  logic [7:0]             retry_cnt_q, retry_cnt_d;
  logic                   lk;
  logic                   inc_loss;
  logic                   inc_retry;

  assign lk = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], pll_locked};
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    inc_loss  = 1'b0;
    inc_retry = 1'b0;

    case (state_q)
      ST_WAIT_LOCK: begin
        if (lk) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = ST_PLL_RST;
          cnt_d     = '0;
          inc_retry = 1'b1;
        end
      end
      ST_STABLE: begin
        if (!lk) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      // soft_reset_req is deliberately not looked at here so HOLD always completes
      ST_HOLD: begin
        if (!lk) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lk) begin
          state_d   = ST_PLL_RST;
          inc_loss  = 1'b1;
          inc_retry = 1'b1;
        end else if (soft_reset_req) begin
          state_d = ST_HOLD;
        end
      end
      ST_PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    // Registered outputs decode the next state so they change on the same edge as the state.
    pll_rst_d   = (state_d == ST_PLL_RST);
    sys_reset_d = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);

    lock_loss_cnt_d = lock_loss_cnt_q;
    if (inc_loss && (lock_loss_cnt_q != 8'hFF)) begin
      lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
    end
    retry_cnt_d = retry_cnt_q;
    if (inc_retry && (retry_cnt_q != 8'hFF)) begin
      retry_cnt_d = retry_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q          <= '0;
      state_q         <= ST_WAIT_LOCK;
      cnt_q           <= '0;
      pll_rst_q       <= 1'b0;
      sys_reset_q     <= 1'b1;
      ready_q         <= 1'b0;
      lock_loss_cnt_q <= 8'd0;
      retry_cnt_q     <= 8'd0;
    end else begin
      sync_q          <= sync_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pll_rst_q       <= pll_rst_d;
      sys_reset_q     <= sys_reset_d;
      ready_q         <= ready_d;
      lock_loss_cnt_q <= lock_loss_cnt_d;
      retry_cnt_q     <= retry_cnt_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_reset     = sys_reset_q;
  assign ready         = ready_q;
  assign state_o       = state_q;
  assign lock_loss_cnt = lock_loss_cnt_q;
  assign retry_cnt     = retry_cnt_q;

endmodule
